// File: rtl/time_disp_if.sv
// Stopwatch display bundle: BCD digits and controls in, scanned
// 5-digit seven-segment drive and hold status out.
interface time_disp_if;
    logic [3:0] hundredths;
    logic [3:0] tenths;
    logic [3:0] sec_lsb;
    logic [3:0] sec_msb;
    logic [3:0] minutes;
    logic       lap;
    logic       lzb;
    logic [4:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       held;

    modport master (
        output hundredths, tenths, sec_lsb, sec_msb, minutes, lap, lzb,
        input  an, seg, dp, held
    );

    modport slave (
        input  hundredths, tenths, sec_lsb, sec_msb, minutes, lap, lzb,
        output an, seg, dp, held
    );
endinterface

// File: rtl/time_disp.sv
// Multiplexed 5-digit stopwatch display with frame snapshot,
// lap hold, leading-zero blanking and inter-digit blanking.
module time_disp #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 50
) (
    input logic       clk,
    input logic       clr_n,
    time_disp_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] ON_END = CW'(SCAN_DIV - BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [19:0]   frame;
    logic          held_q;
    logic          lap_s;
    logic          lap_p;
    logic [4:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic          slot_end;
    logic          frame_end;
    logic          lap_rise;
    logic [3:0]    digit;
    logic          blank_lz;
    logic [6:0]    code;
    logic [4:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign slot_end  = (cnt == LAST);
    assign frame_end = slot_end && (idx == 3'd4);
    assign lap_rise  = lap_s && !lap_p;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt    <= '0;
            idx    <= '0;
            frame  <= '0;
            held_q <= 1'b0;
            lap_s  <= 1'b0;
            lap_p  <= 1'b0;
            an_q   <= 5'b11111;
            seg_q  <= 7'b1111111;
            dp_q   <= 1'b1;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            // Capture a whole frame at once so a scan never mixes two counts
            if (frame_end && !held_q)
                frame <= {bus.minutes, bus.sec_msb, bus.sec_lsb,
                          bus.tenths, bus.hundredths};
            lap_s <= bus.lap;
            lap_p <= lap_s;
            if (lap_rise)
                held_q <= ~held_q;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    always_comb begin
        digit = frame[19:16];
        case (idx)
            3'd0:    digit = frame[3:0];
            3'd1:    digit = frame[7:4];
            3'd2:    digit = frame[11:8];
            3'd3:    digit = frame[15:12];
            default: digit = frame[19:16];
        endcase
    end

    always_comb begin
        code = 7'b0111111;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b0111111;
        endcase
    end

    always_comb begin
        blank_lz = bus.lzb && (idx == 3'd4) && (frame[19:16] == 4'd0);
        an_d     = 5'b11111;
        if (cnt < ON_END)
            an_d = 5'b11111 ^ (5'b00001 << idx);
        seg_d = blank_lz ? 7'b1111111 : code;
        dp_d  = blank_lz || !((idx == 3'd2) || (idx == 3'd4));
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = dp_q;
    assign bus.held = held_q;
endmodule

// File: tb/tb_time_disp.sv
// Directed bench for time_disp with SCAN_DIV=8, BLANK_CYC=2;
// per-cycle anode invariants plus slot-by-slot segment checks.
module tb_time_disp;
    logic clk;
    logic clr_n;
    int   vectors;
    int   miscompares;

    time_disp_if bus ();

    time_disp #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] old_seg [0:4];
    logic [6:0] new_seg [0:4];
    logic       dp_exp  [0:4];
    logic [4:0] prev_an;

    always @(negedge clk) begin
        if (!$isunknown(bus.an)) begin
            vectors++;
            assert ($countones(~bus.an) <= 1) else begin
                miscompares++;
                $error("FAIL onehot an=%b required at most one low", bus.an);
            end
            if (!$isunknown(prev_an) && prev_an != 5'b11111
                && bus.an != 5'b11111) begin
                vectors++;
                assert (bus.an === prev_an) else begin
                    miscompares++;
                    $error("FAIL an_step an=%b prev=%b required via 11111",
                           bus.an, prev_an);
                end
            end
        end
        prev_an = bus.an;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic see_slot(input int k, input logic [6:0] s,
                            input logic d, input string tag);
        logic [4:0] tgt;
        int n;
        tgt = 5'b11111 ^ (5'b00001 << k);
        n = 0;
        while (bus.an !== tgt && n < 100) begin
            tick();
            n++;
        end
        chk({27'd0, bus.an}, {27'd0, tgt}, {tag, "_an"});
        chk({25'd0, bus.seg}, {25'd0, s}, {tag, "_seg"});
        chk({31'd0, bus.dp}, {31'd0, d}, {tag, "_dp"});
        n = 0;
        while (bus.an === tgt && n < 20) begin
            tick();
            n++;
        end
        chk(n, 6, {tag, "_on_len"});
        n = 0;
        while (bus.an === 5'b11111 && n < 20) begin
            tick();
            n++;
        end
        chk(n, 2, {tag, "_blank_len"});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        old_seg[0] = 7'b0010010;
        old_seg[1] = 7'b0011001;
        old_seg[2] = 7'b0110000;
        old_seg[3] = 7'b0100100;
        old_seg[4] = 7'b1111001;
        new_seg[0] = 7'b0000010;
        new_seg[1] = 7'b0000000;
        new_seg[2] = 7'b0010000;
        new_seg[3] = 7'b0010010;
        new_seg[4] = 7'b1111000;
        dp_exp[0] = 1'b1;
        dp_exp[1] = 1'b1;
        dp_exp[2] = 1'b0;
        dp_exp[3] = 1'b1;
        dp_exp[4] = 1'b0;

        clr_n          = 1'b0;
        bus.hundredths = 4'd0;
        bus.tenths     = 4'd0;
        bus.sec_lsb    = 4'd0;
        bus.sec_msb    = 4'd0;
        bus.minutes    = 4'd0;
        bus.lap        = 1'b0;
        bus.lzb        = 1'b0;
        repeat (3) tick();
        chk({27'd0, bus.an}, 32'h1f, "rst_an");
        chk({25'd0, bus.seg}, 32'h7f, "rst_seg");
        chk({31'd0, bus.dp}, 32'd1, "rst_dp");
        chk({31'd0, bus.held}, 32'd0, "rst_held");

        bus.minutes    = 4'd1;
        bus.sec_msb    = 4'd2;
        bus.sec_lsb    = 4'd3;
        bus.tenths     = 4'd4;
        bus.hundredths = 4'd5;
        clr_n          = 1'b1;
        tick();
        chk({27'd0, bus.an}, 32'h1e, "rel_an");
        chk({25'd0, bus.seg}, 32'h40, "rel_seg");

        for (int k = 0; k < 5; k++)
            see_slot(k, 7'b1000000, dp_exp[k], $sformatf("f0_s%0d", k));
        for (int k = 0; k < 5; k++)
            see_slot(k, old_seg[k], dp_exp[k], $sformatf("f1_s%0d", k));

        bus.lap = 1'b1;
        tick();
        bus.lap = 1'b0;
        chk({31'd0, bus.held}, 32'd0, "lap1_early");
        tick();
        chk({31'd0, bus.held}, 32'd1, "lap1_held");
        bus.minutes    = 4'd7;
        bus.sec_msb    = 4'd5;
        bus.sec_lsb    = 4'd9;
        bus.tenths     = 4'd8;
        bus.hundredths = 4'd6;
        for (int k = 1; k < 5; k++)
            see_slot(k, old_seg[k], dp_exp[k], $sformatf("f2_s%0d", k));
        for (int f = 3; f < 6; f++)
            for (int k = 0; k < 5; k++)
                see_slot(k, old_seg[k], dp_exp[k],
                         $sformatf("hold_f%0d_s%0d", f, k));

        bus.lap = 1'b1;
        tick();
        bus.lap = 1'b0;
        tick();
        chk({31'd0, bus.held}, 32'd0, "lap2_released");
        for (int k = 1; k < 5; k++)
            see_slot(k, old_seg[k], dp_exp[k], $sformatf("f6_s%0d", k));
        for (int k = 0; k < 5; k++)
            see_slot(k, new_seg[k], dp_exp[k], $sformatf("f7_s%0d", k));

        bus.minutes    = 4'd0;
        bus.hundredths = 4'hC;
        bus.lzb        = 1'b1;
        see_slot(4, 7'b1111000, 1'b0, "f8_lzb_nonzero");
        see_slot(0, 7'b0111111, 1'b1, "f9_dash");
        see_slot(4, 7'b1111111, 1'b1, "f9_lzb_blank");
        bus.lzb = 1'b0;
        see_slot(4, 7'b1000000, 1'b0, "f10_lzb_off");

        bus.lap = 1'b1;
        tick();
        bus.lap = 1'b0;
        tick();
        chk({31'd0, bus.held}, 32'd1, "lap3_held");
        for (int n = 0; n < 100 && bus.an !== 5'b10111; n++)
            tick();
        tick();
        tick();
        chk({27'd0, bus.an}, 32'h17, "pre_rst_an");
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        chk({27'd0, bus.an}, 32'h1f, "mid_rst_an");
        chk({25'd0, bus.seg}, 32'h7f, "mid_rst_seg");
        chk({31'd0, bus.dp}, 32'd1, "mid_rst_dp");
        chk({31'd0, bus.held}, 32'd0, "mid_rst_held");
        tick();
        chk({27'd0, bus.an}, 32'h1e, "restart_an");
        chk({25'd0, bus.seg}, 32'h40, "restart_seg");
        for (int k = 1; k < 5; k++)
            see_slot(k, 7'b1000000, dp_exp[k], $sformatf("rf0_s%0d", k));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
